spi_mem_burst: RTL and testbench

- Parametrised SPI slave memory; successor to the single-byte SPI memory.
- Adds configurable data/address width, all four SPI modes (CPOL/CPHA), multi-word burst transfers with address auto-increment and wrap, and abort detection.
- Sits between the board SPI pins and on-chip storage.
- Conditions the raw pins internally and owns its memory array.

---
 rtl/spi_mem_burst.sv | 213 +++++++++++++++++++++
 tb/tb_spi_mem_burst.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_burst.sv
// SPI slave memory with burst read/write, address auto-increment with wrap, and abort detection.
// Raw pins are synchronised on clk; all SPI timing is recovered from edge detection on the synced pins.
//
// state    | meaning
// S_IDLE   | waiting for a chip-select falling edge
// S_HEADER | shifting in the R/W bit plus address
// S_WRITE  | shifting in data words, committing each completed word
// S_READ   | shifting out prefetched words on miso_pin
module spi_mem_burst #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_pin,
    input  logic              cs_pin,
    input  logic              mosi_pin,
    output logic              miso_pin,
    output logic              miso_oe,
    output logic              busy,
    output logic              abort,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int HDR_W = ADDR_W + 1;
    localparam int MAX_W = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W);
    localparam logic SCLK_IDLE   = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);
    localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  C_ONE     = CNT_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_WRITE  = 2'd2,
        S_READ   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [CNT_W-1:0]  r_cnt;
    logic [MAX_W-2:0]  r_rx;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_miso;
    logic              r_abort;
    logic              r_fetch;
    logic              r_wr_pend;
    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    logic              w_sclk_s;
    logic              w_cs_s;
    logic              w_mosi_s;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_sample;
    logic              w_shift;
    logic              w_cs_fall;
    logic              w_hdr_last;
    logic              w_word_last;
    logic [HDR_W-1:0]  w_hdr_word;
    logic [DATA_W-1:0] w_data_word;

    // CS sync resets to "low" so a CS already held low at reset release never looks like a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= SCLK_IDLE;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_pin};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = ~r_sclk_d & w_sclk_s;
    assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
    assign w_sample    = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
    assign w_shift     = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;
    assign w_cs_fall   = r_cs_d & ~w_cs_s;
    assign w_hdr_word  = {r_rx[HDR_W-2:0], w_mosi_s};
    assign w_data_word = {r_rx[DATA_W-2:0], w_mosi_s};
    assign w_hdr_last  = (r_state == S_HEADER) && !w_cs_s && w_sample && (r_cnt == HDR_LAST);
    assign w_word_last = ((r_state == S_WRITE) || (r_state == S_READ)) && !w_cs_s && w_sample
                         && (r_cnt == WORD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_cs_s) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hdr_last) begin
                    w_state_nxt = w_hdr_word[ADDR_W] ? S_READ : S_WRITE;
                end
            end
            S_WRITE, S_READ: begin
                if (w_cs_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        miso_oe = (r_state == S_READ);
    end

    // A CS rise takes priority over any sclk edge seen in the same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_wr_data <= '0;
            r_addr    <= '0;
            r_miso    <= 1'b0;
            r_abort   <= 1'b0;
            r_fetch   <= 1'b0;
            r_wr_pend <= 1'b0;
        end else begin
            r_abort   <= 1'b0;
            r_fetch   <= 1'b0;
            r_wr_pend <= 1'b0;
            if (r_wr_pend) begin
                r_addr <= r_addr + A_ONE;
            end
            if (r_fetch) begin
                r_tx <= r_mem[r_addr];
            end
            if (r_state == S_IDLE) begin
                r_miso <= 1'b0;
                if (w_cs_fall) begin
                    r_cnt <= '0;
                end
            end else if (w_cs_s) begin
                r_abort <= (r_cnt != '0);
                r_cnt   <= '0;
                r_miso  <= 1'b0;
            end else if (w_sample) begin
                r_rx <= {r_rx[MAX_W-3:0], w_mosi_s};
                if (w_hdr_last) begin
                    r_cnt   <= '0;
                    r_addr  <= w_hdr_word[ADDR_W-1:0];
                    r_fetch <= w_hdr_word[ADDR_W];
                end else if (w_word_last) begin
                    r_cnt <= '0;
                    if (r_state == S_WRITE) begin
                        r_wr_pend <= 1'b1;
                        r_wr_data <= w_data_word;
                    end else begin
                        r_addr  <= r_addr + A_ONE;
                        r_fetch <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + C_ONE;
                end
            end else if (w_shift && (r_state == S_READ)) begin
                r_miso <= r_tx[DATA_W-1];
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Storage is deliberately not reset; a completed word commits even if CS rises right after it.
    always_ff @(posedge clk) begin
        if (r_wr_pend) begin
            r_mem[r_addr] <= r_wr_data;
        end
    end

    assign miso_pin = r_miso;
    assign abort    = r_abort;
    assign cur_addr = r_addr;

endmodule

// File: tb/tb_spi_mem_burst.sv
// Bench for spi_mem_burst: a default instance (mode 0, 8/7) and a mode 3, 16-bit data / 4-bit address instance.
module tb_spi_mem_burst;

    typedef struct {
        int          u;
        logic        rd;
        int          addr;
        int          n;
        logic [15:0] w0;
        logic [15:0] w1;
        int          end_addr;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
    logic       miso0, oe0, busy0, abort0;
    logic [6:0] addr0;
    logic       sclk1 = 1'b1, cs1 = 1'b1, mosi1 = 1'b0;
    logic       miso1, oe1, busy1, abort1;
    logic [3:0] addr1;

    int checks = 0;
    int errors = 0;
    int ab_cnt0 = 0, ab_cnt1 = 0, ab_run = 0, ab_last_run = 0;
    logic [15:0] exp_q[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    spi_mem_burst dut0 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk0), .cs_pin(cs0), .mosi_pin(mosi0),
        .miso_pin(miso0), .miso_oe(oe0), .busy(busy0), .abort(abort0), .cur_addr(addr0)
    );

    spi_mem_burst #(.DATA_W(16), .ADDR_W(4), .CPOL(1), .CPHA(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk1), .cs_pin(cs1), .mosi_pin(mosi1),
        .miso_pin(miso1), .miso_oe(oe1), .busy(busy1), .abort(abort1), .cur_addr(addr1)
    );

    always @(negedge clk) begin
        if (abort0) begin
            ab_cnt0++;
            ab_run++;
        end else if (ab_run != 0) begin
            ab_last_run = ab_run;
            ab_run = 0;
        end
        if (abort1) ab_cnt1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_busy(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction

    function automatic logic get_oe(input int u);
        return (u == 0) ? oe0 : oe1;
    endfunction

    function automatic logic [31:0] get_addr(input int u);
        return (u == 0) ? 32'(addr0) : 32'(addr1);
    endfunction

    function automatic int get_ab(input int u);
        return (u == 0) ? ab_cnt0 : ab_cnt1;
    endfunction

    task automatic set_cs(input int u, input logic v);
        if (u == 0) cs0 = v;
        else cs1 = v;
    endtask

    // Unit 0 is mode 0 (sample on leading rise), unit 1 is mode 3 (shift on leading fall).
    task automatic spi_bit(input int u, input logic b, output logic rb, output logic oe_s);
        if (u == 0) begin
            mosi0 = b;
            #80;
            rb = miso0;
            oe_s = oe0;
            sclk0 = 1'b1;
            #80;
            sclk0 = 1'b0;
        end else begin
            sclk1 = 1'b0;
            mosi1 = b;
            #80;
            rb = miso1;
            oe_s = oe1;
            sclk1 = 1'b1;
            #80;
        end
    endtask

    task automatic send_bits(input int u, input logic [31:0] val, input int nbits,
                             output logic [31:0] got, output logic oe_any, output logic oe_all);
        logic rb, oe_s;
        got = '0;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(u, val[i], rb, oe_s);
            got[i] = rb;
            oe_any = oe_any | oe_s;
            oe_all = oe_all & oe_s;
        end
    endtask

    task automatic end_cs(input int u, input string tag);
        #80;
        @(negedge clk);
        check({tag, "_busy_before_cs"}, 32'(get_busy(u)), 32'd1);
        set_cs(u, 1'b1);
        repeat (3) @(negedge clk);
        check({tag, "_busy_fall"}, 32'(get_busy(u)), 32'd0);
        #100;
    endtask

    task automatic run_vec(input vec_t v);
        int dw, aw, ab0;
        logic [31:0] hdr, got, word, exp;
        logic oany, oall;
        dw = (v.u == 0) ? 8 : 16;
        aw = (v.u == 0) ? 7 : 4;
        ab0 = get_ab(v.u);
        if (v.rd) begin
            exp_q.push_back(v.w0);
            if (v.n > 1) exp_q.push_back(v.w1);
        end
        hdr = (32'(v.rd) << aw) | 32'(v.addr);
        set_cs(v.u, 1'b0);
        #80;
        send_bits(v.u, hdr, aw + 1, got, oany, oall);
        check("hdr_oe", 32'(oany), 32'd0);
        for (int w = 0; w < v.n; w++) begin
            word = v.rd ? $urandom : 32'((w == 0) ? v.w0 : v.w1);
            send_bits(v.u, word, dw, got, oany, oall);
            if (v.rd) begin
                check("rd_oe", 32'(oall), 32'd1);
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    exp = 32'(exp_q.pop_front());
                    check("read_word", got, exp);
                end
            end else begin
                check("wr_oe", 32'(oany), 32'd0);
            end
        end
        end_cs(v.u, v.rd ? "rd" : "wr");
        check("end_addr", get_addr(v.u), 32'(v.end_addr));
        check("no_abort", 32'(get_ab(v.u) - ab0), 32'd0);
        check("oe_idle", 32'(get_oe(v.u)), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic oany, oall;
        int ab0;

        tbl[0]  = '{u:0, rd:1'b0, addr:'h05, n:2, w0:16'h00A5, w1:16'h003C, end_addr:'h07};
        tbl[1]  = '{u:0, rd:1'b1, addr:'h05, n:2, w0:16'h00A5, w1:16'h003C, end_addr:'h07};
        tbl[2]  = '{u:0, rd:1'b0, addr:'h7F, n:2, w0:16'h0011, w1:16'h0022, end_addr:'h01};
        tbl[3]  = '{u:0, rd:1'b1, addr:'h7F, n:2, w0:16'h0011, w1:16'h0022, end_addr:'h01};
        tbl[4]  = '{u:0, rd:1'b0, addr:'h10, n:1, w0:16'h0077, w1:16'h0000, end_addr:'h11};
        tbl[5]  = '{u:1, rd:1'b0, addr:'h0,  n:1, w0:16'h1234, w1:16'h0000, end_addr:'h1};
        tbl[6]  = '{u:1, rd:1'b0, addr:'hF,  n:1, w0:16'hBEEF, w1:16'h0000, end_addr:'h0};
        tbl[7]  = '{u:1, rd:1'b1, addr:'hF,  n:2, w0:16'hBEEF, w1:16'h1234, end_addr:'h1};
        tbl[8]  = '{u:0, rd:1'b1, addr:'h10, n:1, w0:16'h0077, w1:16'h0000, end_addr:'h11};
        tbl[9]  = '{u:0, rd:1'b0, addr:'h20, n:1, w0:16'h005A, w1:16'h0000, end_addr:'h21};
        tbl[10] = '{u:0, rd:1'b1, addr:'h20, n:1, w0:16'h005A, w1:16'h0000, end_addr:'h21};
        tbl[11] = '{u:0, rd:1'b1, addr:'h05, n:2, w0:16'h00A5, w1:16'h003C, end_addr:'h07};

        repeat (3) @(negedge clk);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_oe0", 32'(oe0), 32'd0);
        check("rst_miso0", 32'(miso0), 32'd0);
        check("rst_abort0", 32'(abort0), 32'd0);
        check("rst_addr0", 32'(addr0), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_addr1", 32'(addr1), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy0", 32'(busy0), 32'd0);
        check("post_rst_busy1", 32'(busy1), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
            #200;
        end

        // Abort mid-data-word: 4 of 8 bits, then CS high.
        ab0 = ab_cnt0;
        cs0 = 1'b0;
        #80;
        send_bits(0, {24'd0, 1'b0, 7'h10}, 8, got, oany, oall);
        send_bits(0, 32'h0000000A, 4, got, oany, oall);
        end_cs(0, "abort_word");
        check("abort_word_count", 32'(ab_cnt0 - ab0), 32'd1);
        check("abort_word_width", 32'(ab_last_run), 32'd1);
        check("abort_word_addr", 32'(addr0), 32'h10);
        #200;
        run_vec(tbl[8]);
        #200;

        // Abort mid-header.
        ab0 = ab_cnt0;
        cs0 = 1'b0;
        #80;
        send_bits(0, 32'h5, 3, got, oany, oall);
        end_cs(0, "abort_hdr");
        check("abort_hdr_count", 32'(ab_cnt0 - ab0), 32'd1);
        check("abort_hdr_addr", 32'(addr0), 32'h11);
        #200;

        // Reset in the middle of a read word, with CS left low afterwards.
        cs0 = 1'b0;
        #80;
        send_bits(0, {24'd0, 1'b1, 7'h05}, 8, got, oany, oall);
        send_bits(0, 32'h0, 4, got, oany, oall);
        check("pre_rst_bits", got, 32'hA);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_oe", 32'(oe0), 32'd0);
        check("mid_rst_miso", 32'(miso0), 32'd0);
        check("mid_rst_abort", 32'(abort0), 32'd0);
        check("mid_rst_addr", 32'(addr0), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bits(0, 32'hFF, 8, got, oany, oall);
        check("cs_low_ignored_busy", 32'(busy0), 32'd0);
        check("cs_low_ignored_addr", 32'(addr0), 32'd0);
        cs0 = 1'b1;
        #200;
        for (int i = 9; i < 12; i++) begin
            run_vec(tbl[i]);
            #200;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
